// File: rtl/raf_pkg.sv
// ---------------------------------------------------------------------------
// raf_pkg
// Shared definitions for the FIFO read-and-filter stage.
//   DATA_W      : default FIFO word width
//   CNT_W       : default width of the accepted-byte counter
//   raf_state_t : read sequencer states (IDLE, REQ, WAIT, CAP)
//   nib_accept  : nibble-compare filter, true when upper nibble > lower nibble
// ---------------------------------------------------------------------------
package raf_pkg;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        CAP  = 2'd3
    } raf_state_t;

    // A byte passes the filter when its upper half, read as an unsigned
    // number, is strictly larger than its lower half. Equal halves fail.
    function automatic logic nib_accept(input logic [DATA_W-1:0] b);
        return (b[DATA_W-1:DATA_W/2] > b[DATA_W/2-1:0]);
    endfunction

endpackage

// File: rtl/sat_cnt.sv
// ---------------------------------------------------------------------------
// sat_cnt
// Up-counter that sticks at all-ones instead of wrapping.
//   CLK : system clock, rising edge
//   RST : synchronous active-high clear
//   inc : count request for this cycle
//   q   : current count
//   sat : high in a cycle where inc arrives while q is already all-ones
// ---------------------------------------------------------------------------
module sat_cnt #(
    parameter int W = 8
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         inc,
    output logic [W-1:0] q,
    output logic         sat
);

    logic at_max;

    assign at_max = &q;

    // The counter only advances while there is headroom left; once it hits
    // all-ones further increments are dropped so the value never wraps back
    // to a small number that would look plausible on the display.
    always_ff @(posedge CLK) begin
        if (RST) begin
            q <= '0;
        end else if (inc && !at_max) begin
            q <= q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    // Flags a lost increment so the parent can keep a sticky overflow bit.
    assign sat = inc & at_max;

endmodule

// File: rtl/fifo_rd_filter.sv
// ---------------------------------------------------------------------------
// fifo_rd_filter
// Drains the display-side byte FIFO one word at a time, checks each word
// against the nibble-compare filter and counts the accepted ones.
//   CLK    : system clock, rising edge
//   RST    : synchronous active-high reset
//   Enwrk  : global work enable
//   ENraf  : read-and-filter enable
//   empty  : FIFO empty flag
//   q      : FIFO read data, valid RD_LAT cycles after the rdreq edge
//   rdreq  : single-cycle FIFO read request
//   bc     : saturating count of accepted bytes
//   last_q : most recently captured byte, accepted or not
//   busy   : high while a read is in flight
//   ovf    : sticky, set when an accept arrives with bc already at maximum
// RD_LAT selects FIFO read latency; 2 inserts a WAIT cycle, any other value
// behaves as 1.
// ---------------------------------------------------------------------------
module fifo_rd_filter #(
    parameter int DATA_W = raf_pkg::DATA_W,
    parameter int CNT_W  = raf_pkg::CNT_W,
    parameter int RD_LAT = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              Enwrk,
    input  logic              ENraf,
    input  logic              empty,
    input  logic [DATA_W-1:0] q,
    output logic              rdreq,
    output logic [CNT_W-1:0]  bc,
    output logic [DATA_W-1:0] last_q,
    output logic              busy,
    output logic              ovf
);

    import raf_pkg::*;

    raf_state_t state;
    raf_state_t state_nxt;
    logic       go;
    logic       cap;
    logic       accept;
    logic       sat;

    assign go = Enwrk & ENraf & ~empty;

    // Use the shared filter function at its native width; other widths fall
    // back to the same upper-half versus lower-half compare written inline.
    if (DATA_W == raf_pkg::DATA_W) begin : g_pkg_filter
        assign accept = nib_accept(q);
    end else begin : g_gen_filter
        assign accept = (q[DATA_W-1:DATA_W/2] > q[DATA_W/2-1:0]);
    end

    // State register. Reset drops any read already issued to the FIFO, so
    // a byte popped but not yet captured is simply never counted.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. The enables are looked at only in IDLE and CAP: once
    // a request has gone out the sequence always runs through to capture,
    // because the FIFO has already popped the word. CAP chains straight into
    // the next REQ so a steady stream costs 1+RD_LAT cycles per byte.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (go) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                state_nxt = (RD_LAT == 2) ? WAIT : CAP;
            end
            WAIT: begin
                state_nxt = CAP;
            end
            CAP: begin
                state_nxt = go ? REQ : IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign rdreq = (state == REQ);
    assign busy  = (state != IDLE);
    assign cap   = (state == CAP);

    // Capture register for the returned word. It keeps its value when the
    // enables drop, so the display still shows the last byte seen.
    always_ff @(posedge CLK) begin
        if (RST) begin
            last_q <= '0;
        end else if (cap) begin
            last_q <= q;
        end
    end

    sat_cnt #(
        .W(CNT_W)
    ) u_bc (
        .CLK(CLK),
        .RST(RST),
        .inc(cap & accept),
        .q  (bc),
        .sat(sat)
    );

    // Overflow flag: once an accepted byte has been lost to saturation the
    // flag stays up until reset, so a stuck 255 on the display can be
    // told apart from exactly 255 accepted bytes.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ovf <= 1'b0;
        end else if (sat) begin
            ovf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fifo_rd_filter.sv
// ---------------------------------------------------------------------------
// tb_fifo_rd_filter
// Runs one RD_LAT=1 instance (lane 0) and one RD_LAT=2 instance (lane 1)
// side by side, each fed by its own FIFO model, and compares them against a
// byte-level reference model of the filter and saturating counter.
// ---------------------------------------------------------------------------
module tb_fifo_rd_filter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst    [2];
    logic       enwrk  [2];
    logic       enraf  [2];
    logic       empty  [2];
    logic [7:0] q      [2];
    logic       rdreq  [2];
    logic       busy   [2];
    logic       ovf    [2];
    logic [7:0] bc     [2];
    logic [7:0] last_q [2];

    fifo_rd_filter #(.DATA_W(8), .CNT_W(8), .RD_LAT(1)) u_dut_lat1 (
        .CLK(clk), .RST(rst[0]), .Enwrk(enwrk[0]), .ENraf(enraf[0]),
        .empty(empty[0]), .q(q[0]), .rdreq(rdreq[0]), .bc(bc[0]),
        .last_q(last_q[0]), .busy(busy[0]), .ovf(ovf[0])
    );

    fifo_rd_filter #(.DATA_W(8), .CNT_W(8), .RD_LAT(2)) u_dut_lat2 (
        .CLK(clk), .RST(rst[1]), .Enwrk(enwrk[1]), .ENraf(enraf[1]),
        .empty(empty[1]), .q(q[1]), .rdreq(rdreq[1]), .bc(bc[1]),
        .last_q(last_q[1]), .busy(busy[1]), .ovf(ovf[1])
    );

    typedef struct {
        logic [7:0] data;
        logic       acc;
    } vec_t;

    vec_t       vecs [12];
    logic [7:0] fifo0 [$];
    logic [7:0] fifo1 [$];
    logic [7:0] stage1;
    int         model_acc  [2];
    logic [7:0] model_last [2];
    int         rd_cnt  [2];
    int         min_gap [2];
    int         max_gap [2];
    int         last_rd [2];
    int         viol    [2];
    int         uflow   [2];
    logic       prev_rd [2];
    int         cyc;
    int         nChecks;
    int         nFails;

    task automatic checkOutput(input string name, input int ln,
                               input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s lane%0d (RD_LAT=%0d): actual 0x%0h required 0x%0h",
                     name, ln, ln + 1, act, exp);
        end
    endtask

    task automatic applyStimulus(input int ln, input logic w, input logic r);
        enwrk[ln] = w;
        enraf[ln] = r;
    endtask

    task automatic resetModel(input int ln);
        model_acc[ln]  = 0;
        model_last[ln] = 8'h00;
    endtask

    task automatic pushByte(input int ln, input logic [7:0] b, input bit counted);
        if (ln == 0) fifo0.push_back(b);
        else         fifo1.push_back(b);
        empty[ln] = 1'b0;
        if (counted) begin
            if ((b >> 4) > (b & 8'h0F)) model_acc[ln]++;
            model_last[ln] = b;
        end
    endtask

    task automatic flushFifo(input int ln);
        if (ln == 0) fifo0.delete();
        else         fifo1.delete();
        empty[ln] = 1'b1;
    endtask

    task automatic clearStats();
        for (int ln = 0; ln < 2; ln++) begin
            rd_cnt[ln]  = 0;
            min_gap[ln] = 1000;
            max_gap[ln] = 0;
            last_rd[ln] = -1;
        end
    endtask

    // One clock: observe rdreq of the finishing cycle, then let the FIFO
    // models react just after the edge and return at the next falling edge.
    task automatic tick();
        logic rd [2];
        int   gap;
        for (int ln = 0; ln < 2; ln++) rd[ln] = (rdreq[ln] === 1'b1);
        @(posedge clk);
        #1;
        for (int ln = 0; ln < 2; ln++) begin
            if (rd[ln]) begin
                if (prev_rd[ln]) viol[ln]++;
                rd_cnt[ln]++;
                if (last_rd[ln] >= 0) begin
                    gap = cyc - last_rd[ln];
                    if (gap < min_gap[ln]) min_gap[ln] = gap;
                    if (gap > max_gap[ln]) max_gap[ln] = gap;
                end
                last_rd[ln] = cyc;
            end
            prev_rd[ln] = rd[ln];
        end
        if (rd[0]) begin
            if (fifo0.size() == 0) begin
                uflow[0]++;
                q[0] = 8'($urandom);
            end else begin
                q[0] = fifo0.pop_front();
            end
        end else begin
            q[0] = 8'($urandom);
        end
        q[1] = stage1;
        if (rd[1]) begin
            if (fifo1.size() == 0) begin
                uflow[1]++;
                stage1 = 8'($urandom);
            end else begin
                stage1 = fifo1.pop_front();
            end
        end else begin
            stage1 = 8'($urandom);
        end
        empty[0] = (fifo0.size() == 0);
        empty[1] = (fifo1.size() == 0);
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((fifo0.size() != 0 || fifo1.size() != 0 ||
                busy[0] !== 1'b0 || busy[1] !== 1'b0) && n < budget) begin
            tick();
            n++;
        end
        nChecks++;
        if (n >= budget) begin
            nFails++;
            $display("[TB] FAIL drain_timeout: still busy after %0d cycles, required idle", n);
        end
    endtask

    task automatic doReset();
        for (int ln = 0; ln < 2; ln++) rst[ln] = 1'b1;
        repeat (3) begin
            tick();
            for (int ln = 0; ln < 2; ln++) begin
                checkOutput("rst_rdreq",  ln, 32'(rdreq[ln]),  32'd0);
                checkOutput("rst_busy",   ln, 32'(busy[ln]),   32'd0);
                checkOutput("rst_bc",     ln, 32'(bc[ln]),     32'd0);
                checkOutput("rst_last_q", ln, 32'(last_q[ln]), 32'd0);
                checkOutput("rst_ovf",    ln, 32'(ovf[ln]),    32'd0);
            end
        end
        for (int ln = 0; ln < 2; ln++) rst[ln] = 1'b0;
    endtask

    task automatic checkLane(input string tag, input int ln);
        int e;
        e = (model_acc[ln] > 255) ? 255 : model_acc[ln];
        checkOutput({tag, "_bc"},     ln, 32'(bc[ln]),     32'(e));
        checkOutput({tag, "_last_q"}, ln, 32'(last_q[ln]), 32'(model_last[ln]));
        checkOutput({tag, "_ovf"},    ln, 32'(ovf[ln]),    (model_acc[ln] > 255) ? 32'd1 : 32'd0);
        checkOutput({tag, "_busy"},   ln, 32'(busy[ln]),   32'd0);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int   n;
        int   tb_bc [2];
        logic [7:0] saved_bc [2];

        vecs[0]  = '{8'h52, 1'b1};
        vecs[1]  = '{8'h25, 1'b0};
        vecs[2]  = '{8'h90, 1'b1};
        vecs[3]  = '{8'h33, 1'b0};
        vecs[4]  = '{8'hF0, 1'b1};
        vecs[5]  = '{8'h0F, 1'b0};
        vecs[6]  = '{8'hFE, 1'b1};
        vecs[7]  = '{8'hEF, 1'b0};
        vecs[8]  = '{8'h10, 1'b1};
        vecs[9]  = '{8'h00, 1'b0};
        vecs[10] = '{8'hFF, 1'b0};
        vecs[11] = '{8'h87, 1'b1};

        nChecks = 0;
        nFails  = 0;
        cyc     = 0;
        stage1  = 8'h00;
        for (int ln = 0; ln < 2; ln++) begin
            rst[ln] = 1'b1;
            applyStimulus(ln, 1'b0, 1'b0);
            empty[ln]   = 1'b1;
            q[ln]       = 8'h00;
            prev_rd[ln] = 1'b0;
            viol[ln]    = 0;
            uflow[ln]   = 0;
            resetModel(ln);
        end
        clearStats();
        @(negedge clk);

        $display("[TB] reset with data waiting and enables high");
        for (int ln = 0; ln < 2; ln++) begin
            applyStimulus(ln, 1'b1, 1'b1);
            pushByte(ln, 8'h52, 1'b1);
        end
        doReset();
        for (int ln = 0; ln < 2; ln++) checkOutput("rdreq_first_idle", ln, 32'(rdreq[ln]), 32'd0);
        tick();
        for (int ln = 0; ln < 2; ln++) checkOutput("rdreq_first_req", ln, 32'(rdreq[ln]), 32'd1);
        drain(50);
        for (int ln = 0; ln < 2; ln++) checkLane("first", ln);

        $display("[TB] four-byte stream");
        for (int ln = 0; ln < 2; ln++) resetModel(ln);
        doReset();
        clearStats();
        for (int ln = 0; ln < 2; ln++) begin
            pushByte(ln, 8'h52, 1'b1);
            pushByte(ln, 8'h25, 1'b1);
            pushByte(ln, 8'h90, 1'b1);
            pushByte(ln, 8'h33, 1'b1);
        end
        drain(100);
        for (int ln = 0; ln < 2; ln++) begin
            checkOutput("stream_rdreq_cnt", ln, 32'(rd_cnt[ln]),  32'd4);
            checkOutput("stream_min_gap",   ln, 32'(min_gap[ln]), 32'(ln + 2));
            checkOutput("stream_max_gap",   ln, 32'(max_gap[ln]), 32'(ln + 2));
            checkOutput("stream_bc",        ln, 32'(bc[ln]),      32'd2);
            checkOutput("stream_last_q",    ln, 32'(last_q[ln]),  32'h33);
            checkLane("stream", ln);
        end

        $display("[TB] gating by empty and ENraf");
        clearStats();
        repeat (20) tick();
        for (int ln = 0; ln < 2; ln++) checkOutput("gate_empty_rdreq", ln, 32'(rd_cnt[ln]), 32'd0);
        for (int ln = 0; ln < 2; ln++) begin
            saved_bc[ln] = model_acc[ln][7:0];
            applyStimulus(ln, 1'b1, 1'b0);
            pushByte(ln, 8'hF1, 1'b0);
            pushByte(ln, 8'hE2, 1'b0);
        end
        repeat (20) tick();
        for (int ln = 0; ln < 2; ln++) begin
            checkOutput("gate_enraf_rdreq", ln, 32'(rd_cnt[ln]), 32'd0);
            checkOutput("gate_enraf_bc",    ln, 32'(bc[ln]),     32'(saved_bc[ln]));
            checkOutput("gate_enraf_busy",  ln, 32'(busy[ln]),   32'd0);
            flushFifo(ln);
            applyStimulus(ln, 1'b1, 1'b1);
        end

        $display("[TB] Enwrk dropped during REQ");
        clearStats();
        for (int ln = 0; ln < 2; ln++) begin
            pushByte(ln, 8'hA1, 1'b1);
            pushByte(ln, 8'h55, 1'b0);
        end
        n = 0;
        while (rdreq[0] !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        for (int ln = 0; ln < 2; ln++) begin
            checkOutput("middrop_req_seen", ln, 32'(rdreq[ln]), 32'd1);
            applyStimulus(ln, 1'b0, 1'b1);
        end
        repeat (10) tick();
        for (int ln = 0; ln < 2; ln++) begin
            checkOutput("middrop_rdreq_cnt", ln, 32'(rd_cnt[ln]), 32'd1);
            checkOutput("middrop_bc",        ln, 32'(bc[ln]),     32'd3);
            checkOutput("middrop_last_q",    ln, 32'(last_q[ln]), 32'hA1);
            checkLane("middrop", ln);
            flushFifo(ln);
            applyStimulus(ln, 1'b1, 1'b1);
        end

        $display("[TB] filter vector table");
        for (int ln = 0; ln < 2; ln++) tb_bc[ln] = model_acc[ln];
        for (int i = 0; i < 12; i++) begin
            for (int ln = 0; ln < 2; ln++) pushByte(ln, vecs[i].data, 1'b1);
            drain(50);
            for (int ln = 0; ln < 2; ln++) begin
                tb_bc[ln] += int'(vecs[i].acc);
                checkOutput("vec_bc",     ln, 32'(bc[ln]),     32'(tb_bc[ln]));
                checkOutput("vec_last_q", ln, 32'(last_q[ln]), 32'(vecs[i].data));
            end
        end
        for (int ln = 0; ln < 2; ln++) checkLane("vec", ln);

        $display("[TB] saturation");
        for (int ln = 0; ln < 2; ln++) resetModel(ln);
        doReset();
        clearStats();
        for (int i = 0; i < 255; i++) begin
            for (int ln = 0; ln < 2; ln++) pushByte(ln, 8'hF0, 1'b1);
        end
        drain(2000);
        for (int ln = 0; ln < 2; ln++) begin
            checkOutput("sat255_bc",  ln, 32'(bc[ln]),  32'd255);
            checkOutput("sat255_ovf", ln, 32'(ovf[ln]), 32'd0);
            checkOutput("sat_min_gap", ln, 32'(min_gap[ln]), 32'(ln + 2));
            checkOutput("sat_max_gap", ln, 32'(max_gap[ln]), 32'(ln + 2));
        end
        for (int k = 0; k < 2; k++) begin
            for (int ln = 0; ln < 2; ln++) pushByte(ln, 8'hF0, 1'b1);
            drain(50);
            for (int ln = 0; ln < 2; ln++) begin
                checkOutput("sat_over_bc",  ln, 32'(bc[ln]),  32'd255);
                checkOutput("sat_over_ovf", ln, 32'(ovf[ln]), 32'd1);
                checkLane("sat_over", ln);
            end
        end
        repeat (10) tick();
        for (int ln = 0; ln < 2; ln++) checkOutput("ovf_sticky", ln, 32'(ovf[ln]), 32'd1);
        for (int ln = 0; ln < 2; ln++) resetModel(ln);
        doReset();

        $display("[TB] reset during WAIT");
        for (int i = 0; i < 5; i++) pushByte(1, 8'hF0, 1'b1);
        drain(100);
        checkOutput("midrst_pre_bc", 1, 32'(bc[1]), 32'd5);
        pushByte(1, 8'hF0, 1'b0);
        n = 0;
        while (rdreq[1] !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        checkOutput("midrst_req_seen", 1, 32'(rdreq[1]), 32'd1);
        tick();
        checkOutput("midrst_wait_busy",  1, 32'(busy[1]),  32'd1);
        checkOutput("midrst_wait_rdreq", 1, 32'(rdreq[1]), 32'd0);
        rst[1] = 1'b1;
        tick();
        rst[1] = 1'b0;
        resetModel(1);
        checkOutput("midrst_bc",     1, 32'(bc[1]),     32'd0);
        checkOutput("midrst_busy",   1, 32'(busy[1]),   32'd0);
        checkOutput("midrst_rdreq",  1, 32'(rdreq[1]),  32'd0);
        checkOutput("midrst_last_q", 1, 32'(last_q[1]), 32'd0);
        clearStats();
        repeat (10) tick();
        checkOutput("midrst_after_rdreq", 1, 32'(rd_cnt[1]), 32'd0);
        checkLane("midrst_after", 1);

        $display("[TB] randomized traffic with enable toggling");
        for (int ln = 0; ln < 2; ln++) resetModel(ln);
        doReset();
        for (int c = 0; c < 500; c++) begin
            for (int ln = 0; ln < 2; ln++) begin
                if ($urandom_range(3) == 0) pushByte(ln, 8'($urandom), 1'b1);
                if ($urandom_range(7) == 0) enwrk[ln] = ~enwrk[ln];
                if ($urandom_range(7) == 0) enraf[ln] = ~enraf[ln];
            end
            tick();
        end
        for (int ln = 0; ln < 2; ln++) applyStimulus(ln, 1'b1, 1'b1);
        drain(3000);
        for (int ln = 0; ln < 2; ln++) begin
            checkLane("random", ln);
            checkOutput("rdreq_back_to_back", ln, 32'(viol[ln]),  32'd0);
            checkOutput("fifo_underflow",     ln, 32'(uflow[ln]), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
